// File: rtl/alu_div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per clock,
// with operands in and results out over separate valid/ready handshakes.
module alu_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic                  is_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_by_zero
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t                  state_reg, state_next;
    logic [CW-1:0]           count_reg, count_next;
    logic [DATA_WIDTH-1:0]   rem_work_reg, rem_work_next;
    logic [DATA_WIDTH-1:0]   quo_work_reg, quo_work_next;
    logic [DATA_WIDTH-1:0]   div_mag_reg, div_mag_next;
    logic                    neg_quo_reg, neg_quo_next;
    logic                    neg_rem_reg, neg_rem_next;
    logic [DATA_WIDTH-1:0]   quotient_reg, quotient_next;
    logic [DATA_WIDTH-1:0]   remainder_reg, remainder_next;
    logic                    dbz_reg, dbz_next;

    // One extra bit on the trial subtraction keeps 2^(W-1) magnitudes from wrapping.
    logic [DATA_WIDTH:0]     rem_shift;
    logic [DATA_WIDTH:0]     trial_diff;
    logic [DATA_WIDTH-1:0]   rem_iter;
    logic [DATA_WIDTH-1:0]   quo_iter;
    logic                    a_neg;
    logic                    b_neg;

    assign rem_shift  = {rem_work_reg, quo_work_reg[DATA_WIDTH-1]};
    assign trial_diff = rem_shift - {1'b0, div_mag_reg};
    assign rem_iter   = trial_diff[DATA_WIDTH] ? rem_shift[DATA_WIDTH-1:0]
                                               : trial_diff[DATA_WIDTH-1:0];
    assign quo_iter   = {quo_work_reg[DATA_WIDTH-2:0], ~trial_diff[DATA_WIDTH]};
    assign a_neg      = is_signed & dividend[DATA_WIDTH-1];
    assign b_neg      = is_signed & divisor[DATA_WIDTH-1];

    assign in_ready    = (state_reg == IDLE);
    assign out_valid   = (state_reg == DONE);
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        rem_work_next  = rem_work_reg;
        quo_work_next  = quo_work_reg;
        div_mag_next   = div_mag_reg;
        neg_quo_next   = neg_quo_reg;
        neg_rem_next   = neg_rem_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        dbz_next       = dbz_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    count_next    = '0;
                    rem_work_next = '0;
                    quo_work_next = a_neg ? -dividend : dividend;
                    div_mag_next  = b_neg ? -divisor : divisor;
                    neg_quo_next  = a_neg ^ b_neg;
                    neg_rem_next  = a_neg;
                    if (divisor == '0) begin
                        // Result is fixed, so skip the iterations entirely.
                        state_next     = DONE;
                        quotient_next  = '1;
                        remainder_next = dividend;
                        dbz_next       = 1'b1;
                    end else begin
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                rem_work_next = rem_iter;
                quo_work_next = quo_iter;
                count_next    = count_reg + 1'b1;
                if (count_reg == LAST_ITER) begin
                    state_next     = DONE;
                    count_next     = '0;
                    quotient_next  = neg_quo_reg ? -quo_iter : quo_iter;
                    remainder_next = neg_rem_reg ? -rem_iter : rem_iter;
                    dbz_next       = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next     = IDLE;
                    quotient_next  = '0;
                    remainder_next = '0;
                    dbz_next       = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            rem_work_reg  <= '0;
            quo_work_reg  <= '0;
            div_mag_reg   <= '0;
            neg_quo_reg   <= 1'b0;
            neg_rem_reg   <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            rem_work_reg  <= rem_work_next;
            quo_work_reg  <= quo_work_next;
            div_mag_reg   <= div_mag_next;
            neg_quo_reg   <= neg_quo_next;
            neg_rem_reg   <= neg_rem_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            dbz_reg       <= dbz_next;
        end
    end

endmodule
